// File: rtl/aes_mix_columns_iter.sv
// aes_mix_columns_iter: iterative AES MixColumns / InvMixColumns over the full 128-bit state.
// The state is buffered once and mixed in place, ColsPerCycle columns per clock.
// Optional final-round bypass is compiled in when AES_MIXCOL_BYPASS_EN is defined; it adds
// the bypass_i input port.

package aes_pkg;
    typedef enum logic [2:0] {
        CIPH_FWD = 3'b001,
        CIPH_INV = 3'b010
    } ciph_op_e;
endpackage

module aes_mix_columns_iter #(
    parameter int unsigned ColsPerCycle = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  aes_pkg::ciph_op_e    op_i,
`ifdef AES_MIXCOL_BYPASS_EN
    input  logic                 bypass_i,
`endif
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [3:0][3:0][7:0] state_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [3:0][3:0][7:0] state_o,
    output logic                 err_o
);
    import aes_pkg::*;

    if (!(ColsPerCycle == 1 || ColsPerCycle == 2 || ColsPerCycle == 4)) begin : gen_bad_cfg
        $error("aes_mix_columns_iter: ColsPerCycle must be 1, 2 or 4");
    end

    localparam logic [2:0] CntStep = 3'(ColsPerCycle);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } fsm_e;

    // GF(2^8) multiply by x, reduced by the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Single-column mix; byte i of the column is row i of the state.
    function automatic logic [3:0][7:0] mix_column(input logic [3:0][7:0] a, input logic inv);
        logic [3:0][7:0] x2, x4, x8, y;
        logic [1:0] i0, i1, i2, i3;
        for (int i = 0; i < 4; i++) begin
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
        end
        for (int i = 0; i < 4; i++) begin
            i0 = 2'(i);
            i1 = i0 + 2'd1;
            i2 = i0 + 2'd2;
            i3 = i0 + 2'd3;
            if (inv) begin
                // {0e, 0b, 0d, 09} circulant
                y[i] = (x8[i0] ^ x4[i0] ^ x2[i0]) ^
                       (x8[i1] ^ x2[i1] ^ a[i1]) ^
                       (x8[i2] ^ x4[i2] ^ a[i2]) ^
                       (x8[i3] ^ a[i3]);
            end else begin
                // {02, 03, 01, 01} circulant
                y[i] = x2[i0] ^ (x2[i1] ^ a[i1]) ^ a[i2] ^ a[i3];
            end
        end
        return y;
    endfunction

    fsm_e                  st_q;
    logic [2:0]            cnt_q;
    logic [2:0]            cnt_next;
    logic [3:0][3:0][7:0]  state_q;
    logic [3:0][3:0][7:0]  state_mixed;
    ciph_op_e              op_q;
    logic                  err_q;
    logic                  out_valid_q;
    logic                  accept;
    logic                  op_bad;
    logic                  load_bypass;
    logic                  mix_inv;

    logic [ColsPerCycle-1:0][1:0]       col_idx;
    logic [ColsPerCycle-1:0][3:0][7:0]  col_in;
    logic [ColsPerCycle-1:0][3:0][7:0]  col_out;

`ifdef AES_MIXCOL_BYPASS_EN
    assign load_bypass = bypass_i;
`else
    assign load_bypass = 1'b0;
`endif

    // Anything other than CIPH_INV mixes forward, including illegal op codes.
    assign mix_inv  = (op_q == CIPH_INV);
    assign op_bad   = (op_i != CIPH_FWD) && (op_i != CIPH_INV);
    assign cnt_next = cnt_q + CntStep;
    assign accept   = in_valid_i && in_ready_o;

    // One mixer per column handled in a cycle; counter selects which group is current.
    for (genvar g = 0; g < int'(ColsPerCycle); g++) begin : gen_mix
        assign col_idx[g] = cnt_q[1:0] + 2'(g);
        for (genvar r = 0; r < 4; r++) begin : gen_row
            assign col_in[g][r] = state_q[r][col_idx[g]];
        end
        assign col_out[g] = mix_column(col_in[g], mix_inv);
    end

    // Write the freshly mixed column group back over the buffered state.
    always_comb begin
        state_mixed = state_q;
        for (int g = 0; g < int'(ColsPerCycle); g++) begin
            for (int r = 0; r < 4; r++) begin
                state_mixed[r][col_idx[g]] = col_out[g][r];
            end
        end
    end

    // Ready depends only on FSM state and downstream ready, so DONE can hand over and reload.
    always_comb begin
        in_ready_o = 1'b0;
        unique case (st_q)
            StIdle:  in_ready_o = 1'b1;
            StDone:  in_ready_o = out_ready_i;
            default: in_ready_o = 1'b0;
        endcase
    end

    // Control FSM, state buffer, counter and sticky error flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_q        <= StIdle;
            cnt_q       <= '0;
            state_q     <= '0;
            op_q        <= CIPH_FWD;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            // Reached from IDLE or from DONE while the result is being consumed.
            state_q <= state_i;
            op_q    <= op_i;
            cnt_q   <= '0;
            if (op_bad) begin
                err_q <= 1'b1;
            end
            if (load_bypass) begin
                st_q        <= StDone;
                out_valid_q <= 1'b1;
            end else begin
                st_q        <= StBusy;
                out_valid_q <= 1'b0;
            end
        end else begin
            unique case (st_q)
                StBusy: begin
                    state_q <= state_mixed;
                    cnt_q   <= cnt_next;
                    if (cnt_next == 3'd4) begin
                        st_q        <= StDone;
                        out_valid_q <= 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready_i) begin
                        st_q        <= StIdle;
                        out_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid_o = out_valid_q;
    assign state_o     = state_q;
    assign err_o       = err_q;

endmodule

// File: doc/aes_mix_columns_iter.md
Name: aes_mix_columns_iter

Overview:
- Iterative MixColumns/InvMixColumns stage for the full 128-bit AES state.
- Upstream is ShiftRows; downstream is AddRoundKey.
- Processes the state column by column through ColsPerCycle instances of the single-column mixer. This trades latency for area in the compact cipher core.
- valid/ready handshake on both sides; one state buffered internally.

Parameters:
- ColsPerCycle, 1, columns mixed per clock; legal values 1, 2, 4. Any other value is an elaboration error.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset; synchronous, active-high.
- op_i  input  aes_pkg::ciph_op_e  cipher direction; sampled only on input handshake.
- in_valid_i  input  1  upstream state valid.
- in_ready_o  output  1  stage can accept a state.
- state_i  input  [3:0][3:0][7:0]  state, indexed [row][col].
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  downstream accepts result.
- state_o  output  [3:0][3:0][7:0]  mixed state, indexed [row][col].
- err_o  output  1  sticky: an op value other than CIPH_FWD/CIPH_INV was accepted.

Behaviour:
- Column j is bytes state[0..3][j]; row r maps to single-column byte index r.
- FSM states: IDLE, BUSY, DONE. Encoding is free.
- Reset (rst_i high at a clock edge), from any state:
  - FSM to IDLE, column counter to 0, state register to 0, latched op to CIPH_FWD.
  - Outputs: out_valid_o=0, in_ready_o=1, state_o=0, err_o=0.
  - Any in-flight state is discarded.
- IDLE:
  - in_ready_o=1, out_valid_o=0.
  - On in_valid_i&&in_ready_o: latch state_i and op_i, counter=0, go to BUSY.
- BUSY:
  - in_ready_o=0.
  - Each cycle, columns counter..counter+ColsPerCycle-1 are replaced in place by their mixed value.
  - Counter advances by ColsPerCycle.
  - When the last column group is written, go to DONE.
  - BUSY lasts exactly 4/ColsPerCycle cycles.
- DONE:
  - out_valid_o=1; state_o is driven from the state register.
  - state_o and out_valid_o stay stable while out_ready_i=0.
  - in_ready_o=out_ready_i, so a new state is accepted in the same cycle the result is consumed.
  - On out_valid_o&&out_ready_i:
    - if in_valid_i is also high: load the new state, go to BUSY (back-to-back, no bubble in IDLE);
    - otherwise: go to IDLE.
- Latency: handshake-in to out_valid_o = 4/ColsPerCycle + 1 cycles. Throughput is one state per 4/ColsPerCycle + 1 cycles.
- state_o is only meaningful while out_valid_o=1. It holds the register contents otherwise; the bench must not check it then.
- Op handling:
  - CIPH_FWD: MixColumns.
  - CIPH_INV: InvMixColumns.
  - Any other value: the forward result is produced and err_o sets; it stays set until reset.
- op_i changes after acceptance have no effect.
- No combinational path from in_valid_i to out_valid_o. in_ready_o depends combinationally only on the FSM state and out_ready_i.
- Counter does not wrap while in BUSY. It is cleared on each load.

Optional Feature:
- Macro: AES_MIXCOL_BYPASS_EN.
- Defined:
  - Adds input port bypass_i (1 bit), sampled with op_i on the input handshake.
  - If latched bypass=1, the FSM goes IDLE->DONE directly and state_o equals state_i unmodified. Latency is 1 cycle.
  - Used for the final round, which skips MixColumns.
  - err_o is still evaluated for bypassed states.
- Undefined: no bypass_i port; every accepted state is mixed.

Test Plan:
1. ColsPerCycle=1, op=CIPH_FWD, column 0 = {db,13,53,45} (row0..3), other columns = {f2,0a,22,5c}, {01,01,01,01}, {c6,c6,c6,c6}, out_ready_i=1 -> out_valid_o asserts 5 cycles after the handshake; columns = {8e,4d,a1,bc}, {9f,dc,58,9d}, {01,01,01,01}, {c6,c6,c6,c6}.
2. Same as scenario 1 but op=CIPH_INV with the forward outputs as input -> the original input state is returned exactly; err_o=0.
3. ColsPerCycle=4, stream 3 back-to-back states with in_valid_i held high -> out_valid_o every 2 cycles; in_ready_o high only in DONE cycles that have out_ready_i=1; results match a golden model.
4. Hold out_ready_i=0 for 10 cycles while in DONE -> state_o and out_valid_o stable, in_ready_o=0, a pending in_valid_i is not accepted; on release, the result is consumed once.
5. Assert rst_i for 1 cycle during BUSY (ColsPerCycle=1, after 2 columns) -> next cycle: IDLE, out_valid_o=0, in_ready_o=1, state_o=0; no output is produced for the aborted state.
6. Accept op=3'b111 (illegal) -> forward result produced, err_o=1 and held through subsequent legal operations until rst_i. With AES_MIXCOL_BYPASS_EN and bypass_i=1: state_o = state_i, 1 cycle after the handshake.
